mem_stage_sb: RTL and testbench

//  Parametrised MIPS16 MEM pipeline stage: successor to the fixed 16-bit MEM stage.

---
 rtl/mem_stage_sb_pkg.sv | 29 ++
 rtl/mem_stage_sb_if.sv | 35 +++
 rtl/mem_stage_sb_store_buffer.sv | 66 ++++++
 rtl/mem_stage_sb.sv | 103 ++++++++++
 tb/tb_mem_stage_sb.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sb_pkg.sv
// Shared types and default widths for the MIPS16 MEM stage and its store buffer.
package mips16_mem_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_REG_AW   = 3;
  localparam int unsigned DEF_SB_DEPTH = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sb_entry_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_DATA_W-1:0] alu_result;
    logic                  wb_en;
    logic [DEF_REG_AW-1:0] dest;
  } mem_req_t;

  // read&write together is an illegal encoding and is handled as a store
  function automatic logic is_load_op(input logic mem_read, input logic mem_write);
    return mem_read & ~mem_write;
  endfunction

endpackage

// File: rtl/mem_stage_sb_if.sv
// EX->MEM request channel and MEM->WB result channel of the MIPS16 MEM stage.
interface mem_stage_sb_if #(
  parameter int unsigned DATA_W = mips16_mem_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = mips16_mem_pkg::DEF_ADDR_W,
  parameter int unsigned REG_AW = mips16_mem_pkg::DEF_REG_AW
);

  logic              in_valid;
  logic              in_ready;
  logic              in_mem_read;
  logic              in_mem_write;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] in_alu_result;
  logic              in_wb_en;
  logic [REG_AW-1:0] in_dest;

  logic              out_valid;
  logic              out_wb_en;
  logic [REG_AW-1:0] out_dest;
  logic [DATA_W-1:0] out_wb_data;

  modport master (
    output in_valid, in_mem_read, in_mem_write, in_addr, in_wdata,
           in_alu_result, in_wb_en, in_dest,
    input  in_ready, out_valid, out_wb_en, out_dest, out_wb_data
  );

  modport slave (
    input  in_valid, in_mem_read, in_mem_write, in_addr, in_wdata,
           in_alu_result, in_wb_en, in_dest,
    output in_ready, out_valid, out_wb_en, out_dest, out_wb_data
  );

endinterface

// File: rtl/mem_stage_sb_store_buffer.sv
// Circular store buffer: posted {addr,data} entries drained in order from the head,
// with a parallel address match that reports the youngest hit.
module mem_store_buffer import mips16_mem_pkg::*; #(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  parameter  int unsigned DEPTH  = DEF_SB_DEPTH,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{addr: push_addr, data: push_data};
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_addr = entries[head].addr;
  assign head_data = entries[head].data;
  assign full      = (count == CNT_W'(DEPTH));

  // Scan oldest to youngest so the last match overwrites earlier ones.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && entries[head + PTR_W'(i)].addr == match_addr) begin
        hit      = 1'b1;
        hit_data = entries[head + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/mem_stage_sb.sv
// MIPS16 MEM stage with posted-store buffer, single-port data memory and MEM/WB register.
// Optional MEM_STORE_FWD_EN: loads hitting the buffer take the youngest entry instead of stalling.
module mem_stage_sb import mips16_mem_pkg::*; #(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned REG_AW   = DEF_REG_AW,
  parameter int unsigned SB_DEPTH = DEF_SB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  mem_stage_sb_if.slave              bus,
  output logic [REG_AW-1:0]          mem_op_dest,
  output logic [$clog2(SB_DEPTH):0]  sb_count
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              is_store;
  logic              is_load;
  logic              accept;
  logic              drain;
  logic              sb_full;
  logic              sb_hit;
  logic [DATA_W-1:0] hit_data;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] load_data;

  assign is_store = bus.in_mem_write;
  assign is_load  = is_load_op(bus.in_mem_read, bus.in_mem_write);
  assign accept   = bus.in_valid && bus.in_ready;
  // The memory port goes to an accepted load first; otherwise the head entry drains.
  assign drain    = (sb_count != '0) && !(accept && is_load);

  mem_store_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (accept && is_store),
    .push_addr  (bus.in_addr),
    .push_data  (bus.in_wdata),
    .pop        (drain),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .match_addr (bus.in_addr),
    .hit        (sb_hit),
    .hit_data   (hit_data),
    .count      (sb_count),
    .full       (sb_full)
  );

  always_comb begin
    bus.in_ready = 1'b1;
    if (is_store) begin
      bus.in_ready = !sb_full;
    end else if (is_load) begin
`ifdef MEM_STORE_FWD_EN
      bus.in_ready = !sb_full;
`else
      bus.in_ready = !sb_full && !sb_hit;
`endif
    end
  end

  always_comb begin
    load_data = mem[bus.in_addr];
`ifdef MEM_STORE_FWD_EN
    if (sb_hit) load_data = hit_data;
`endif
  end

`ifndef MEM_STORE_FWD_EN
  logic unused_hit_data;
  assign unused_hit_data = ^hit_data;
`endif

  // No reset on the array; a drain coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && drain) mem[head_addr] <= head_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_wb_en   <= 1'b0;
      bus.out_dest    <= '0;
      bus.out_wb_data <= '0;
      mem_op_dest     <= '0;
    end else begin
      bus.out_valid <= accept;
      bus.out_wb_en <= accept && bus.in_wb_en;
      mem_op_dest   <= (accept && bus.in_wb_en) ? bus.in_dest : '0;
      if (accept) begin
        bus.out_dest    <= bus.in_dest;
        bus.out_wb_data <= is_load ? load_data : bus.in_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Self-checking bench for mem_stage_sb: queue/array reference model plus directed literal checks.
module tb_mem_stage_sb;
  import mips16_mem_pkg::*;

  localparam int unsigned DW    = DEF_DATA_W;
  localparam int unsigned AW    = DEF_ADDR_W;
  localparam int unsigned RW    = DEF_REG_AW;
  localparam int unsigned DEPTH = DEF_SB_DEPTH;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef MEM_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] mem_op_dest;
  logic [CW-1:0] sb_count;

  mem_stage_sb_if #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW)) bus ();

  mem_stage_sb #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .SB_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_op_dest (mem_op_dest),
    .sb_count    (sb_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: pending stores in program order, plus architectural memory.
  sb_entry_t     sbq [$];
  logic [DW-1:0] mem_m [int];
  bit            live    = 1'b0;
  bit            e_valid = 1'b0;
  bit            e_wb_en = 1'b0;
  bit            e_known = 1'b1;
  logic [RW-1:0] e_dest  = '0;
  logic [DW-1:0] e_data  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bit h;
    h = 1'b0;
    d = '0;
    foreach (sbq[i]) if (sbq[i].addr == a) begin h = 1'b1; d = sbq[i].data; end
    return h;
  endfunction

  function automatic bit model_ready();
    logic [DW-1:0] d;
    bit            h;
    h = model_hit(bus.in_addr, d);
    if (bus.in_mem_write) return sbq.size() < DEPTH;
    if (bus.in_mem_read)  return (sbq.size() < DEPTH) && (FWD || !h);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit            acc, ld, h;
    logic [DW-1:0] hd;
    if (rst) begin
      sbq.delete();
      e_valid = 1'b0; e_wb_en = 1'b0; e_dest = '0; e_data = '0; e_known = 1'b1;
      live    = 1'b1;
    end else begin
      ld  = bus.in_mem_read && !bus.in_mem_write;
      acc = bus.in_valid && model_ready();
      h   = model_hit(bus.in_addr, hd);
      e_valid = acc;
      e_wb_en = acc && bus.in_wb_en;
      if (acc) begin
        e_dest = bus.in_dest;
        if (ld) begin
          if (h) begin e_data = hd; e_known = 1'b1; end
          else if (mem_m.exists(int'(bus.in_addr))) begin
            e_data = mem_m[int'(bus.in_addr)]; e_known = 1'b1;
          end else e_known = 1'b0;
        end else begin
          e_data = bus.in_alu_result; e_known = 1'b1;
        end
      end
      if (!(acc && ld) && sbq.size() > 0) begin
        mem_m[int'(sbq[0].addr)] = sbq[0].data;
        sbq.delete(0);
      end
      if (acc && bus.in_mem_write) sbq.push_back('{addr: bus.in_addr, data: bus.in_wdata});
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("in_ready",    32'(bus.in_ready),  32'(model_ready()));
      chk("sb_count",    32'(sb_count),      32'(sbq.size()));
      chk("out_valid",   32'(bus.out_valid), 32'(e_valid));
      chk("mem_op_dest", 32'(mem_op_dest),   (e_valid && e_wb_en) ? 32'(e_dest) : 32'd0);
      if (e_valid) begin
        chk("out_wb_en", 32'(bus.out_wb_en), 32'(e_wb_en));
        chk("out_dest",  32'(bus.out_dest),  32'(e_dest));
        if (e_known) chk("out_wb_data", 32'(bus.out_wb_data), 32'(e_data));
      end
    end
  end

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0; bus.in_wb_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] alu,
                       input bit wb, input logic [RW-1:0] d, output int stalls);
    bus.in_valid = 1'b1; bus.in_mem_read = rd; bus.in_mem_write = wr; bus.in_addr = a;
    bus.in_wdata = wd; bus.in_alu_result = alu; bus.in_wb_en = wb; bus.in_dest = d;
    stalls = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && stalls < 32) begin stalls++; @(negedge clk); end
    if (bus.in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL handshake_timeout: in_ready %b after %0d cycles, required 1", bus.in_ready, stalls);
    end
    tick();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int st;
    idle();
    bus.in_addr = '0; bus.in_wdata = '0; bus.in_alu_result = '0; bus.in_dest = '0;
    repeat (3) tick();
    chk("reset_out_valid",   32'(bus.out_valid), 32'd0);
    chk("reset_mem_op_dest", 32'(mem_op_dest),   32'd0);
    chk("reset_sb_count",    32'(sb_count),      32'd0);
    chk("reset_in_ready",    32'(bus.in_ready),  32'd1);
    rst = 1'b0;
    tick();

    // 1: posted store drains on the first idle cycle, later load sees it in memory
    issue(0, 1, 8'h10, 16'h00A5, 16'h0, 0, 3'd0, st);
    chk("t1_count_after_store", 32'(sb_count), 32'd1);
    tick();
    chk("t1_count_after_idle", 32'(sb_count), 32'd0);
    repeat (2) tick();
    issue(1, 0, 8'h10, 16'h0, 16'h0, 1, 3'd2, st);
    chk("t1_load_data", 32'(bus.out_wb_data), 32'h00A5);
    chk("t1_load_dest", 32'(mem_op_dest),     32'd2);

    // 2: back-to-back stores drain in order; last writer per address wins
    for (int i = 1; i <= 5; i++) begin
      issue(0, 1, (i % 2) ? 8'h50 : 8'h51, 16'(i * 16'h0101), 16'h0, 0, 3'd0, st);
      chk("t2_store_stalls", 32'(st), 32'd0);
    end
    repeat (2) tick();
    issue(1, 0, 8'h50, 16'h0, 16'h0, 1, 3'd1, st);
    chk("t2_load_50", 32'(bus.out_wb_data), 32'h0505);
    issue(1, 0, 8'h51, 16'h0, 16'h0, 1, 3'd1, st);
    chk("t2_load_51", 32'(bus.out_wb_data), 32'h0404);

    // 3: load right behind a store to the same address
    issue(0, 1, 8'h20, 16'h1234, 16'h0, 0, 3'd0, st);
    issue(1, 0, 8'h20, 16'h0, 16'h0, 1, 3'd4, st);
    chk("t3_stalls",    32'(st),              FWD ? 32'd0 : 32'd1);
    chk("t3_load_data", 32'(bus.out_wb_data), 32'h1234);

    // 4: two stores to one address, youngest is observed and ends in memory
    issue(0, 1, 8'h30, 16'h1111, 16'h0, 0, 3'd0, st);
    issue(0, 1, 8'h30, 16'h2222, 16'h0, 0, 3'd0, st);
    issue(1, 0, 8'h30, 16'h0, 16'h0, 1, 3'd5, st);
    chk("t4_load_data", 32'(bus.out_wb_data), 32'h2222);
    repeat (2) tick();
    issue(1, 0, 8'h30, 16'h0, 16'h0, 1, 3'd5, st);
    chk("t4_mem_final", 32'(bus.out_wb_data), 32'h2222);

    // 5: ALU op passes result through, then a bubble
    issue(0, 0, 8'h00, 16'h0, 16'hBEEF, 1, 3'd3, st);
    chk("t5_mem_op_dest", 32'(mem_op_dest),     32'd3);
    chk("t5_wb_data",     32'(bus.out_wb_data), 32'hBEEF);
    tick();
    chk("t5_bubble_dest",  32'(mem_op_dest),   32'd0);
    chk("t5_bubble_valid", 32'(bus.out_valid), 32'd0);

    // 6: reset discards a pending store and suppresses its drain
    issue(0, 1, 8'h40, 16'h7777, 16'h0, 0, 3'd0, st);
    repeat (2) tick();
    issue(0, 1, 8'h40, 16'h9999, 16'h0, 0, 3'd0, st);
    rst = 1'b1;
    tick();
    chk("t6_sb_count",  32'(sb_count),      32'd0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_in_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b0;
    tick();
    issue(1, 0, 8'h40, 16'h0, 16'h0, 1, 3'd6, st);
    chk("t6_mem_kept", 32'(bus.out_wb_data), 32'h7777);

    // Random phase over a small address pool, warmed so every load is predictable
    for (int i = 0; i < 8; i++) issue(0, 1, 8'(8'h80 + i), 16'($urandom), 16'h0, 0, 3'd0, st);
    repeat (3) tick();
    for (int k = 0; k < 400; k++) begin
      int unsigned   r;
      logic [AW-1:0] a;
      r = $urandom_range(0, 9);
      a = 8'(8'h80 + $urandom_range(0, 7));
      if (r == 0)
        tick();
      else if (r < 5)
        issue($urandom_range(0, 3) == 0, 1, a, 16'($urandom), 16'($urandom),
              $urandom_range(0, 1) == 1, 3'($urandom), st);
      else if (r < 8)
        issue(1, 0, a, 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1, 3'($urandom), st);
      else
        issue(0, 0, a, 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1, 3'($urandom), st);
    end
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
